// File: rtl/fetch_queue_pkg.sv
// Shared rv32imc pipeline types used by the fetch queue.
package rv32imc_types;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pc_next;
  } fetch_entry_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc_next;
  } pend_entry_t;

endpackage

// File: rtl/fetch_queue_sync_fifo.sv
// Generic synchronous FIFO with clear; count is one bit wider than the
// pointers so that full and empty are distinct.
module sync_fifo #(
  parameter int  DEPTH  = 4,
  parameter type elem_t = logic [31:0]
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  elem_t                  push_data,
  input  logic                   pop,
  input  logic                   clear,
  output logic [$clog2(DEPTH):0] count,
  output elem_t                  head
);

  localparam int PTR_W = $clog2(DEPTH);

  elem_t            mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  // pointer and occupancy tracking; clear wins over a same-cycle push/pop
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // storage array, not reset
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_queue.sv
// Fetch-to-decode decoupling buffer: pairs in-order imem responses with
// their request PCs, issues credit-based stall, drops wrong-path words.
module fetch_queue
  import rv32imc_types::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_req_pc,
  input  logic [31:0] i_req_pc_next,
  input  logic        imem_resp,
  input  logic [31:0] imem_rdata,
  input  logic        i_flush,
  output logic        o_stall,
  output logic        o_valid,
  output logic [31:0] o_inst,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc_next,
  input  logic        i_ready
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W:0]   outstanding;
  logic [PTR_W:0]   occ;
  logic [PTR_W:0]   drop_cnt;
  logic [PTR_W+1:0] credits;
  logic             drop_now;
  logic             inst_push;
  logic             inst_pop;
  pend_entry_t      pend_in;
  pend_entry_t      pend_head;
  fetch_entry_t     inst_in;
  fetch_entry_t     inst_head;

  assign pend_in   = '{pc: i_req_pc, pc_next: i_req_pc_next};
  assign drop_now  = imem_resp && (drop_cnt != '0);
  assign inst_push = imem_resp && !drop_now;
  assign inst_pop  = o_valid && i_ready;
  assign inst_in   = '{inst: imem_rdata, pc: pend_head.pc, pc_next: pend_head.pc_next};

  sync_fifo #(.DEPTH(DEPTH), .elem_t(pend_entry_t)) pend_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (i_req),
    .push_data (pend_in),
    .pop       (imem_resp),
    .clear     (1'b0),
    .count     (outstanding),
    .head      (pend_head)
  );

  sync_fifo #(.DEPTH(DEPTH), .elem_t(fetch_entry_t)) inst_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inst_push),
    .push_data (inst_in),
    .pop       (inst_pop),
    .clear     (i_flush),
    .count     (occ),
    .head      (inst_head)
  );

  // wrong-path accounting: a flush marks every older in-flight request for discard
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (i_flush) begin
      drop_cnt <= outstanding - {{PTR_W{1'b0}}, imem_resp};
    end else if (drop_now) begin
      drop_cnt <= drop_cnt - (PTR_W+1)'(1);
    end
  end

  // dropped requests keep their credit until the response comes back
  assign credits = {1'b0, outstanding} + {1'b0, occ};
  assign o_stall = credits >= (PTR_W+2)'(DEPTH);

  // head presentation, zeroed while empty
  always_comb begin
    o_valid   = (occ != '0);
    o_inst    = 32'h0;
    o_pc      = 32'h0;
    o_pc_next = 32'h0;
    if (o_valid) begin
      o_inst    = inst_head.inst;
      o_pc      = inst_head.pc;
      o_pc_next = inst_head.pc_next;
    end else begin
      o_inst    = 32'h0;
      o_pc      = 32'h0;
      o_pc_next = 32'h0;
    end
  end

endmodule
